// File: rtl/fp_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_add_sequencer: 4-deep operand FIFO feeding an external FP adder, with   |
// | IDLE/ISSUE/HOLD handshake. Optional FP_SEQ_SPECIAL_EN: Inf/NaN bypass.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_add_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_en,
   input  logic [31:0] add_sum,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        out_exc
);

   localparam int          DEPTH = 4;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] fifo_mem [DEPTH];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic [31:0] add_a_q, add_a_d;
   logic [31:0] add_b_q, add_b_d;
   logic [31:0] out_sum_q, out_sum_d;
   logic        out_exc_q, out_exc_d;
   logic        push;
   logic        pop;
   logic        special;

   // Gated by rst so nothing is accepted while reset is held.
   assign in_ready = ~rst & (count_q < 3'd4);
   assign push     = in_valid & in_ready;

`ifdef FP_SEQ_SPECIAL_EN
   assign special = (add_a_q[30:23] == 8'hFF) | (add_b_q[30:23] == 8'hFF);
`else
   assign special = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      out_sum_d = out_sum_q;
      out_exc_d = out_exc_q;
      pop       = 1'b0;
      add_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q != 3'd0) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            add_en    = ~special;
            out_sum_d = special ? QNAN : add_sum;
            out_exc_d = special;
            state_d   = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (count_q != 3'd0) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         {add_a_d, add_b_d} = fifo_mem[rd_ptr_q];
         rd_ptr_d           = rd_ptr_q + 2'd1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         count_q   <= 3'd0;
         add_a_q   <= 32'd0;
         add_b_q   <= 32'd0;
         out_sum_q <= 32'd0;
         out_exc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         out_sum_q <= out_sum_d;
         out_exc_q <= out_exc_d;
      end
   end

   // Storage needs no reset: entries are only read when count says they are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {in_a, in_b};
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign out_valid = (state_q == HOLD);
   assign out_sum   = out_sum_q;
   assign out_exc   = out_exc_q;

endmodule
`default_nettype wire

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  pair accepted on an edge where in_valid=1 and in_ready=1
- in_a  in  32  IEEE-754 single-precision operand A
- in_b  in  32  IEEE-754 single-precision operand B
- add_a  out  32  operand A to the downstream single-precision adder
- add_b  out  32  operand B to the downstream single-precision adder
- add_en  out  1  enable to the adder
- add_sum  in  32  combinational sum returned by the adder
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  32  captured sum
- out_exc  out  1  result was produced by the special-value bypass

Function
REQ-003 The operand buffer SHALL be a 4-entry FIFO of {in_a,in_b} pairs, with 2-bit read and write pointers that wrap modulo 4 and a 3-bit count from 0 to 4.
REQ-004 in_ready SHALL equal (count<4) and SHALL be 0 while rst is high; there is no input-to-output pass-through.
REQ-005 The FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-006 IDLE -> ISSUE on an edge where count>0; that edge pops the FIFO head into the add_a and add_b registers.
REQ-007 ISSUE SHALL last exactly one cycle with add_en=1; add_en SHALL be 0 in every other state.
REQ-008 ISSUE -> HOLD on the next edge, which captures add_sum into out_sum; out_valid SHALL be 1 throughout HOLD.
REQ-009 In HOLD, on an edge with out_ready=1:
- if count>0, go to ISSUE and pop the next pair;
- otherwise go to IDLE.
REQ-010 HOLD SHALL persist, and out_sum SHALL stay stable, while out_ready=0.
REQ-011 Latency from the acceptance edge into an empty, idle block to the first cycle of out_valid=1 SHALL be 2 cycles; with out_ready held at 1, results SHALL issue one every 2 cycles.
REQ-012 A push and a pop on the same edge SHALL leave count unchanged; the pushed entry is written at the write pointer.
REQ-013 add_a and add_b SHALL hold their last values outside ISSUE.
REQ-014 Results SHALL emerge in acceptance order.

Reset
REQ-015 While rst=1, the block SHALL asynchronously force:
- state=IDLE, count=0, both pointers=0;
- add_a=0, add_b=0, add_en=0;
- out_valid=0, out_sum=0, out_exc=0.
REQ-016 Reset mid-operation SHALL discard all buffered and in-flight pairs and emit no result for them.
REQ-017 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-018 With FP_SEQ_SPECIAL_EN defined, a popped pair in which either operand has exponent 8'hFF SHALL behave as follows:
- add_en stays 0 during its ISSUE cycle;
- out_sum is captured as 32'h7FC00000;
- out_exc=1 in HOLD.
Non-special pairs SHALL give out_exc=0.
REQ-019 Without FP_SEQ_SPECIAL_EN, every ISSUE cycle SHALL assert add_en, and out_exc SHALL be constant 0.

Verification
REQ-020 Push in_a=32'h40C00000, in_b=32'hC1400000 into an idle block with out_ready=1 -> add_en high for one cycle, then out_valid=1 two cycles after acceptance with out_sum=32'hC0C00000.
REQ-021 Offer 6 pairs on consecutive edges with out_ready=0 -> exactly 5 accepted (in_ready=0 on the 6th), count=4, out_valid held with the first sum.
REQ-022 With out_ready=1, stream 4 pairs (1.0+1.0, 2.0+2.0, 3.0+3.0, 4.0+4.0) -> out_sum 32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000 in order, out_valid asserted every other cycle.
REQ-023 Assert rst during ISSUE with 3 pairs buffered -> all outputs zero immediately, in_ready=0 during reset, and no result appears after release.
REQ-024 With FP_SEQ_SPECIAL_EN defined, push in_a=32'h7F800000, in_b=32'h3F800000 -> add_en stays 0, out_sum=32'h7FC00000, out_exc=1.
REQ-025 Without FP_SEQ_SPECIAL_EN, push the same pair -> add_en=1 for one cycle, out_exc=0, and out_sum equals add_sum.
